// File: rtl/uart_rx_engine.sv
// UART receive engine: oversampled start detect, 2-of-3 bit voting,
// 5-8 data bits, optional parity, one stop bit, valid/ack output word.
module uart_rx_engine #(
  parameter int SAMPLE      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic       rx_en,
  input  logic       rxd,
  input  logic [1:0] data_bits,
  input  logic       parity_en,
  input  logic       parity_odd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       parity_err,
  output logic       frame_err,
  output logic       break_det,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(SAMPLE);
  localparam logic [CW-1:0] C_LO  = CW'(SAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_MID = CW'(SAMPLE / 2);
  localparam logic [CW-1:0] C_DEC = CW'(SAMPLE / 2 + 1);
  localparam logic [CW-1:0] C_END = CW'(SAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxd_s;
  logic [CW-1:0]          cnt, cnt_n;
  logic [2:0]             bitidx, bitidx_n;
  logic [7:0]             shreg, shreg_n;
  logic                   par, par_n;
  logic                   perr, perr_n;
  logic                   zero, zero_n;
  logic [1:0]             votes;
  logic                   maj, dec, wrap, load;
  logic [2:0]             last;

  assign rxd_s = sync[SYNC_STAGES-1];
  assign dec   = sample_tick && (cnt == C_DEC);
  assign wrap  = sample_tick && (cnt == C_END);
  assign maj   = (votes[0] & votes[1]) | (votes[0] & rxd_s) |
                 (votes[1] & rxd_s);
  assign last  = {1'b0, data_bits} + 3'd4;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], rxd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      bitidx <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      perr   <= 1'b0;
      zero   <= 1'b0;
      votes  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bitidx <= bitidx_n;
      shreg  <= shreg_n;
      par    <= par_n;
      perr   <= perr_n;
      zero   <= zero_n;
      if (sample_tick && cnt == C_LO)  votes[0] <= rxd_s;
      if (sample_tick && cnt == C_MID) votes[1] <= rxd_s;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitidx_n = bitidx;
    shreg_n  = shreg;
    par_n    = par;
    perr_n   = perr;
    zero_n   = zero;
    load     = 1'b0;
    if (sample_tick && state != IDLE)
      cnt_n = (cnt == C_END) ? '0 : cnt + CW'(1);
    unique case (state)
      IDLE: begin
        // the detecting tick is cnt 0, so the next tick is cnt 1
        if (sample_tick && rx_en && !rxd_s) begin
          state_n  = START;
          cnt_n    = CW'(1);
          bitidx_n = '0;
          shreg_n  = '0;
          par_n    = 1'b0;
          perr_n   = 1'b0;
          zero_n   = 1'b1;
        end
      end
      START: begin
        if (dec && maj) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (wrap) begin
          state_n  = DATA;
          bitidx_n = '0;
        end
      end
      DATA: begin
        if (dec) begin
          shreg_n[bitidx] = maj;
          par_n           = par ^ maj;
          if (maj) zero_n = 1'b0;
        end
        if (wrap) begin
          if (bitidx == last)
            state_n = parity_en ? PARITY : STOP;
          else
            bitidx_n = bitidx + 3'd1;
        end
      end
      PARITY: begin
        if (dec) begin
          perr_n = ((par ^ maj) != parity_odd);
          if (maj) zero_n = 1'b0;
        end
        if (wrap) state_n = STOP;
      end
      STOP: begin
        // leave before the wrap so an early next start edge is caught
        if (dec) begin
          load    = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!rx_en) begin
      state_n = IDLE;
      cnt_n   = '0;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else if (load) begin
      rx_data    <= shreg;
      rx_valid   <= 1'b1;
      parity_err <= perr;
      frame_err  <= !maj;
      break_det  <= zero & !maj;
      if (rx_valid && !rx_ack) overrun <= 1'b1;
      else if (rx_ack)         overrun <= 1'b0;
    end else if (rx_ack && rx_valid) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: frames driven one tick group
// (4 clk, tick on the first) at a time, SAMPLE=16.
module tb_uart_rx_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_tick;
  logic       rx_en;
  logic       rxd;
  logic [1:0] data_bits;
  logic       parity_en;
  logic       parity_odd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       parity_err;
  logic       frame_err;
  logic       break_det;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;

  uart_rx_engine #(
    .SAMPLE     (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .rx_en      (rx_en),
    .rxd        (rxd),
    .data_bits  (data_bits),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .break_det  (break_det),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic group(input logic b, input logic ack);
    @(negedge clk);
    rxd         = b;
    sample_tick = 1'b1;
    rx_ack      = ack;
    repeat (3) begin
      @(negedge clk);
      sample_tick = 1'b0;
      rx_ack      = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) group(1'b1, 1'b0);
  endtask

  // gb: frame bit index (1 = data bit 0) to glitch mid-bit, -1 = none
  task automatic send(input logic [7:0] d, input logic pb,
                      input logic stp, input int gb,
                      input logic ack_ld);
    logic [11:0] fr;
    int          n;
    int          nd;
    fr = '0;
    nd = int'(data_bits) + 5;
    for (int i = 0; i < nd; i++) fr[1+i] = d[i];
    n = 1 + nd;
    if (parity_en) begin
      fr[n] = pb;
      n++;
    end
    fr[n] = stp;
    n++;
    for (int b = 0; b < n; b++)
      for (int g = 0; g < 16; g++)
        group(fr[b] ^ (b == gb && g == 8),
              ack_ld && b == n - 1 && g == 10);
    idle(32);
  endtask

  task automatic ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] db, input logic pe,
                     input logic po);
    data_bits  = db;
    parity_en  = pe;
    parity_odd = po;
  endtask

  initial begin
    rst         = 1'b1;
    sample_tick = 1'b0;
    rx_en       = 1'b1;
    rxd         = 1'b1;
    rx_ack      = 1'b0;
    cfg(2'd3, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_flags", {parity_err, frame_err, break_det}, 0);
    rst = 1'b0;
    idle(4);

    send(8'hA5, 1'b0, 1'b1, -1, 1'b0);
    chk("a5_valid", rx_valid, 1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_flags", {parity_err, frame_err, overrun}, 0);
    chk("a5_busy", busy, 0);
    ack();
    chk("a5_ack", rx_valid, 0);
    chk("a5_hold", rx_data, 8'hA5);

    cfg(2'd1, 1'b1, 1'b0);
    send(8'h2B, 1'b0, 1'b1, -1, 1'b0);
    chk("p_data", rx_data, 8'h2B);
    chk("p_ok", parity_err, 0);
    ack();
    send(8'h2B, 1'b1, 1'b1, -1, 1'b0);
    chk("p_bad_valid", rx_valid, 1);
    chk("p_bad_data", rx_data, 8'h2B);
    chk("p_bad", parity_err, 1);
    ack();

    cfg(2'd3, 1'b0, 1'b0);
    group(1'b0, 1'b0);
    group(1'b0, 1'b0);
    group(1'b0, 1'b0);
    idle(32);
    chk("fs_valid", rx_valid, 0);
    chk("fs_busy", busy, 0);
    send(8'h3C, 1'b0, 1'b1, -1, 1'b0);
    chk("3c_data", rx_data, 8'h3C);
    chk("3c_valid", rx_valid, 1);
    ack();

    send(8'h55, 1'b0, 1'b0, -1, 1'b0);
    chk("fe_data", rx_data, 8'h55);
    chk("fe_ferr", frame_err, 1);
    chk("fe_brk", break_det, 0);
    ack();
    cfg(2'd3, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b0, -1, 1'b0);
    chk("brk_data", rx_data, 8'h00);
    chk("brk_ferr", frame_err, 1);
    chk("brk_det", break_det, 1);
    chk("brk_perr", parity_err, 0);
    chk("brk_valid", rx_valid, 1);
    ack();

    cfg(2'd3, 1'b0, 1'b0);
    send(8'h11, 1'b0, 1'b1, -1, 1'b0);
    send(8'h22, 1'b0, 1'b1, -1, 1'b0);
    chk("ov_data", rx_data, 8'h22);
    chk("ov_set", overrun, 1);
    chk("ov_valid", rx_valid, 1);
    ack();
    chk("ov_ack_valid", rx_valid, 0);
    chk("ov_ack_clr", overrun, 0);
    send(8'h33, 1'b0, 1'b1, -1, 1'b0);
    send(8'h44, 1'b0, 1'b1, -1, 1'b1);
    chk("co_valid", rx_valid, 1);
    chk("co_ovr", overrun, 0);
    chk("co_data", rx_data, 8'h44);
    ack();

    for (int b = 0; b < 4; b++)
      for (int g = 0; g < 16; g++)
        if (b < 3 || g < 6) group((b == 0) ? 1'b0 : 1'b1, 1'b0);
    chk("en_busy", busy, 1);
    rx_en = 1'b0;
    @(negedge clk);
    chk("en_drop", busy, 0);
    rxd = 1'b1;
    idle(8);
    rx_en = 1'b1;
    idle(32);
    chk("en_novalid", rx_valid, 0);

    send(8'h96, 1'b0, 1'b1, 3, 1'b0);
    chk("gl1_data", rx_data, 8'h96);
    send(8'h69, 1'b0, 1'b1, 1, 1'b0);
    chk("gl2_data", rx_data, 8'h69);
    chk("gl2_ovr", overrun, 1);

    for (int g = 0; g < 40; g++) group(g < 16 ? 1'b0 : 1'b1, 1'b0);
    chk("mr_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_data", rx_data, 0);
    chk("mr_valid", rx_valid, 0);
    chk("mr_busy0", busy, 0);
    chk("mr_ovr", overrun, 0);
    chk("mr_flags", {parity_err, frame_err, break_det}, 0);
    rst = 1'b0;
    idle(4);
    send(8'h5A, 1'b0, 1'b1, -1, 1'b0);
    chk("post_data", rx_data, 8'h5A);
    chk("post_valid", rx_valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
